// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD timing controller: supported panel IDs,
// their timing sets and the controller state encoding.
package lcd_pkg;

   localparam logic [15:0] ID_7084 = 16'h7084;
   localparam logic [15:0] ID_4342 = 16'h4342;

   typedef struct packed {
      logic [10:0] h_sync;
      logic [10:0] h_bp;
      logic [10:0] h_disp;
      logic [10:0] h_fp;
      logic [10:0] h_total;
      logic [10:0] v_sync;
      logic [10:0] v_bp;
      logic [10:0] v_disp;
      logic [10:0] v_fp;
      logic [10:0] v_total;
   } timing_t;

   localparam timing_t TIMING_7084 = '{
      h_sync: 11'd128, h_bp: 11'd88, h_disp: 11'd800, h_fp: 11'd40, h_total: 11'd1056,
      v_sync: 11'd2,   v_bp: 11'd33, v_disp: 11'd480, v_fp: 11'd10, v_total: 11'd525
   };

   localparam timing_t TIMING_4342 = '{
      h_sync: 11'd41, h_bp: 11'd2, h_disp: 11'd480, h_fp: 11'd2, h_total: 11'd525,
      v_sync: 11'd10, v_bp: 11'd2, v_disp: 11'd272, v_fp: 11'd2, v_total: 11'd286
   };

   typedef enum logic [2:0] {
      S_WAIT_ID,
      S_CFG,
      S_PWR,
      S_RUN,
      S_ERR
   } state_t;

endpackage

// File: rtl/lcd_timing_rom.sv
// Combinational lookup from panel ID to its timing set; o_valid is low for
// unsupported IDs.
module lcd_timing_rom
   import lcd_pkg::*;
(
   input  logic [15:0] i_lcd_id,
   output timing_t     o_timing,
   output logic        o_valid
);

   logic        w_hit;
   logic [10:0] w_h_sum;
   logic [10:0] w_v_sum;

   always_comb begin
      o_timing = '0;
      w_hit    = 1'b0;
      case (i_lcd_id)
         ID_7084: begin
            o_timing = TIMING_7084;
            w_hit    = 1'b1;
         end
         ID_4342: begin
            o_timing = TIMING_4342;
            w_hit    = 1'b1;
         end
         default: begin
            o_timing = '0;
            w_hit    = 1'b0;
         end
      endcase
   end

   // The controller derives the active-region end from total minus front
   // porch, so a record is only usable if its four segments sum to the total.
   assign w_h_sum = o_timing.h_sync + o_timing.h_bp + o_timing.h_disp + o_timing.h_fp;
   assign w_v_sum = o_timing.v_sync + o_timing.v_bp + o_timing.v_disp + o_timing.v_fp;
   assign o_valid = w_hit && (w_h_sum == o_timing.h_total) && (w_v_sum == o_timing.v_total);

endmodule

// File: rtl/lcd_timing_ctrl.sv
// LCD timing controller: identifies the panel, holds it in reset for a while,
// then scans frames and produces sync, data-enable and pixel request signals.
module lcd_timing_ctrl
   import lcd_pkg::*;
#(
   parameter int RST_HOLD = 1024,
   parameter int ID_WAIT  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] lcd_id,
   input  logic [15:0] pixel_data,
   output logic        data_req,
   output logic [10:0] pixel_xpos,
   output logic [10:0] pixel_ypos,
   output logic [10:0] h_disp,
   output logic [10:0] v_disp,
   output logic        lcd_hs,
   output logic        lcd_vs,
   output logic        lcd_de,
   output logic [15:0] lcd_rgb,
   output logic        lcd_bl,
   output logic        lcd_rst_n,
   output logic        cfg_err
);

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_wait_cnt;
   timing_t     w_rom_timing;
   logic        w_rom_valid;
   timing_t     r_timing;
   logic [10:0] r_h_cnt;
   logic [10:0] r_v_cnt;
   logic        r_hs;
   logic        r_vs;
   logic        r_de;
   logic        w_run;
   logic [10:0] w_h_start;
   logic [10:0] w_h_end;
   logic [10:0] w_v_start;
   logic [10:0] w_v_end;
   logic        w_h_last;
   logic        w_v_last;
   logic        w_h_active;
   logic        w_v_active;

   lcd_timing_rom u_rom (
      .i_lcd_id (lcd_id),
      .o_timing (w_rom_timing),
      .o_valid  (w_rom_valid)
   );

   // The wait counter times both the ID settle delay and the panel reset hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_WAIT_ID;
         r_wait_cnt <= '0;
      end else begin
         r_state <= w_next;
         if ((w_next == r_state) && ((r_state == S_WAIT_ID) || (r_state == S_PWR)))
            r_wait_cnt <= r_wait_cnt + 32'd1;
         else
            r_wait_cnt <= '0;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_WAIT_ID: if (r_wait_cnt == 32'(ID_WAIT - 1))  w_next = S_CFG;
         S_CFG:     w_next = w_rom_valid ? S_PWR : S_ERR;
         S_PWR:     if (r_wait_cnt == 32'(RST_HOLD - 1)) w_next = S_RUN;
         S_RUN:     w_next = S_RUN;
         S_ERR:     w_next = S_ERR;
         default:   w_next = S_WAIT_ID;
      endcase
   end

   always_comb begin
      w_run     = (r_state == S_RUN);
      lcd_bl    = w_run;
      lcd_rst_n = w_run;
      cfg_err   = (r_state == S_ERR);
   end

   assign w_h_start  = r_timing.h_sync + r_timing.h_bp;
   assign w_h_end    = r_timing.h_total - r_timing.h_fp;
   assign w_v_start  = r_timing.v_sync + r_timing.v_bp;
   assign w_v_end    = r_timing.v_total - r_timing.v_fp;
   assign w_h_last   = (r_h_cnt == r_timing.h_total - 11'd1);
   assign w_v_last   = (r_v_cnt == r_timing.v_total - 11'd1);
   assign w_h_active = (r_h_cnt >= w_h_start) && (r_h_cnt < w_h_end);
   assign w_v_active = (r_v_cnt >= w_v_start) && (r_v_cnt < w_v_end);

   assign data_req   = w_run && w_h_active && w_v_active;
   assign pixel_xpos = data_req ? (r_h_cnt - w_h_start) : 11'd0;
   assign pixel_ypos = data_req ? (r_v_cnt - w_v_start) : 11'd0;

   // Counters sit at the origin outside RUN so scanning always starts at (0,0);
   // sync and enable are registered, keeping them aligned with the returned pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_timing <= '0;
         r_h_cnt  <= '0;
         r_v_cnt  <= '0;
         r_hs     <= 1'b1;
         r_vs     <= 1'b1;
         r_de     <= 1'b0;
      end else begin
         if ((r_state == S_CFG) && w_rom_valid)
            r_timing <= w_rom_timing;
         if (w_run) begin
            if (w_h_last) begin
               r_h_cnt <= '0;
               r_v_cnt <= w_v_last ? 11'd0 : (r_v_cnt + 11'd1);
            end else begin
               r_h_cnt <= r_h_cnt + 11'd1;
            end
         end else begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
         end
         r_hs <= !(w_run && (r_h_cnt < r_timing.h_sync)) && (r_state != S_ERR);
         r_vs <= !(w_run && (r_v_cnt < r_timing.v_sync)) && (r_state != S_ERR);
         r_de <= data_req;
      end
   end

   assign h_disp  = r_timing.h_disp;
   assign v_disp  = r_timing.v_disp;
   assign lcd_hs  = r_hs;
   assign lcd_vs  = r_vs;
   assign lcd_de  = r_de;
   assign lcd_rgb = r_de ? pixel_data : 16'h0;

endmodule
